stack_op_controller: RTL and testbench
======================================

# stack_op_controller

Multi-cycle sequencer for the CPU stack: accepts PUSH/POP/CALL/RET requests from the control unit, performs the required stack-memory accesses over a req/ack port, and drives the 2-bit update-mode input of the stack pointer register. It reads the current SP, range-checks it against the stack window, and commits the SP change only in the final cycle(s) of an operation.

## Interface
- Parameters:
  - REG_BITS, 32, SP/address/data width
  - STACK_BASE, 32'h0000_0400, empty-stack SP value (stack grows down)
  - STACK_LIMIT, 32'h0000_0300, lowest legal SP value
- Ports (one clock `clk`; `reset` is synchronous, active-high):
  - clk  in  1  clock
  - reset  in  1  synchronous active-high reset
  - op_valid  in  1  operation request
  - op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
  - op_ready  out  1  controller idle, can accept
  - wdata0  in  REG_BITS  PUSH value / CALL return PC
  - wdata1  in  REG_BITS  CALL frame pointer
  - op_done  out  1  one-cycle completion pulse
  - op_err  out  1  with op_done: bounds violation, nothing done
  - rdata0  out  REG_BITS  POP value / RET return PC
  - rdata1  out  REG_BITS  RET frame pointer
  - sp_in  in  REG_BITS  current SP from stack pointer register
  - stack_update_mode  out  2  00 hold, 01 sp+1, 10 sp-2, 11 sp-1
  - mem_req, mem_we  out  1  memory request / write enable
  - mem_addr, mem_wdata  out  REG_BITS  address / write data
  - mem_rdata  in  REG_BITS  read data, valid with mem_ack
  - mem_ack  in  1  access complete (same-cycle ack allowed)

## Operation
- States: IDLE, CHK, MEM0, MEM1, UPD, UPD2.
- op_ready = (state==IDLE). Accept on op_valid && op_ready: latch op, wdata0/1, sp_in (sp_q); go CHK.
- CHK: bounds test. Fail → op_done=1, op_err=1, mode 00, → IDLE. Pass → MEM0.
  - PUSH fails if sp_q-1 < STACK_LIMIT; CALL if sp_q-2 < STACK_LIMIT; POP if sp_q+1 > STACK_BASE; RET if sp_q+2 > STACK_BASE. Compare unsigned in REG_BITS+1 bits (no wrap).
- Accesses (addresses from sp_q):
  - PUSH: MEM0 write wdata0 @ sp_q-1.
  - CALL: MEM0 write wdata0 @ sp_q-1; MEM1 write wdata1 @ sp_q-2.
  - POP: MEM0 read sp_q → rdata0.
  - RET: MEM0 read sp_q+1 → rdata0; MEM1 read sp_q → rdata1.
- MEMx holds mem_req and stable addr/we/wdata until mem_ack; advances on ack.
- UPD: mode = 11 (PUSH), 10 (CALL), 01 (POP, RET); op_done=1 except RET. RET → UPD2: mode 01 again, op_done=1. Then IDLE.
- rdata0/1 update on the capturing ack; hold until the next accepted op.
- SP is modified only in UPD/UPD2; no partial SP update on error or reset.

## Timing
- Reset: state IDLE, op_ready=1, op_done=0, op_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stack_update_mode=00, rdata0=rdata1=0.
- Zero-wait latency (accept edge = cycle 0): op_done in cycle 3 for PUSH/POP, 4 for CALL, 5 for RET; error in cycle 1. Each wait cycle adds one.
- New SP visible on sp_in the cycle after op_done.
- op_valid while busy is ignored (no queue).
- Reset mid-operation: abort at that edge; outputs to reset values; SP unchanged unless UPD was already taken (RET in UPD2: first +1 already committed).

## Configuration
- STACK_OP_BOUNDS_CHECK_EN defined: CHK performs checks as above.
- Undefined: CHK always passes, op_err tied 0, addresses and SP wrap mod 2^REG_BITS; latency unchanged.

## Structure
- Package stack_ctrl_pkg: op codes, stack_update_mode codes, state enum.
- Sub-module stack_bounds_check: combinational op/sp_in/params → violation flag; instantiated only under STACK_OP_BOUNDS_CHECK_EN.

## Test plan
- sp_in=0x400, PUSH wdata0=0xAA, immediate ack → write 0xAA @0x3FF, mode 11 one cycle, op_done cycle 3.
- sp_in=0x3FE, CALL pc=0x40 fp=0x80 then RET with model memory, ack delayed 2 cycles → writes @0x3FD,@0x3FC; RET rdata0=0x40, rdata1=0x80, two mode-01 cycles, SP back 0x3FE.
- sp_in=0x400, POP → op_done+op_err cycle 1, no mem_req, mode 00; with macro undefined → read @0x400, no error.
- sp_in=0x301, CALL → error; sp_in=0x302 → succeeds, SP=0x300.
- reset asserted during MEM1 of CALL → next cycle IDLE, mem_req=0, mode 00, SP unchanged.
- op_valid held high while busy → exactly one op accepted per op_ready cycle.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared op codes, SP update modes and sequencer states
//
// Purpose : types shared by stack_op_controller and stack_bounds_check.
// Contents: stack_op_e (request op codes), sp_mode_e (stack pointer register
//           update-mode codes), state_e (sequencer states).

package stack_ctrl_pkg;

    // Request op codes from the control unit.
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } stack_op_e;

    // Update-mode codes understood by the stack pointer register.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_INC1 = 2'b01,
        MODE_DEC2 = 2'b10,
        MODE_DEC1 = 2'b11
    } sp_mode_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_MEM0 = 3'd2,
        S_MEM1 = 3'd3,
        S_UPD  = 3'd4,
        S_UPD2 = 3'd5
    } state_e;

endpackage

// File: rtl/stack_bounds_check.sv
// rtl/stack_bounds_check.sv - combinational stack window check for one operation
//
// Purpose : flags an operation whose SP change would leave the stack window
//           [STACK_LIMIT, STACK_BASE]. All arithmetic is done one bit wider than
//           REG_BITS so that SP values near 0 or near all-ones never wrap.
// Ports   :
//   op        in  2         operation code (stack_op_e encoding)
//   sp        in  REG_BITS  SP value the operation starts from
//   violation out 1         operation would move SP outside the window

module stack_bounds_check
    import stack_ctrl_pkg::*;
#(
    parameter int                  REG_BITS    = 32,
    parameter logic [REG_BITS-1:0] STACK_BASE  = 32'h0000_0400,
    parameter logic [REG_BITS-1:0] STACK_LIMIT = 32'h0000_0300
) (
    input  logic [1:0]          op,
    input  logic [REG_BITS-1:0] sp,
    output logic                violation
);

    localparam int XW = REG_BITS + 1;

    logic [XW-1:0] sp_x;
    logic [XW-1:0] base_x;
    logic [XW-1:0] limit_x;

    assign sp_x    = {1'b0, sp};
    assign base_x  = {1'b0, STACK_BASE};
    assign limit_x = {1'b0, STACK_LIMIT};

    // "sp-n < limit" is rewritten as "sp < limit+n" so no subtraction can
    // underflow; the extra bit keeps limit+n and sp+n from overflowing.
    always_comb begin
        violation = 1'b0;
        case (stack_op_e'(op))
            OP_PUSH: violation = (sp_x < (limit_x + XW'(1)));
            OP_CALL: violation = (sp_x < (limit_x + XW'(2)));
            OP_POP:  violation = ((sp_x + XW'(1)) > base_x);
            OP_RET:  violation = ((sp_x + XW'(2)) > base_x);
            default: violation = 1'b0;
        endcase
    end

endmodule

// File: rtl/stack_op_controller.sv
// rtl/stack_op_controller.sv - multi-cycle PUSH/POP/CALL/RET stack sequencer
//
// Purpose : accepts one stack operation at a time, performs its stack-memory
//           accesses over a req/ack port and drives the SP register update
//           mode only in the final cycle(s) of the operation.
// Config  : STACK_OP_BOUNDS_CHECK_EN - when defined, CHK rejects operations
//           that would leave [STACK_LIMIT, STACK_BASE]; when undefined, CHK
//           always passes, op_err stays 0 and addresses/SP wrap.
// Ports   :
//   clk, reset              clock, synchronous active-high reset
//   op_valid, op, op_ready  request handshake (op: 00 PUSH 01 POP 10 CALL 11 RET)
//   wdata0, wdata1          PUSH value / CALL return PC, CALL frame pointer
//   op_done, op_err         completion pulse, bounds violation (with op_done)
//   rdata0, rdata1          POP value / RET return PC, RET frame pointer
//   sp_in                   current SP from the stack pointer register
//   stack_update_mode       00 hold, 01 sp+1, 10 sp-2, 11 sp-1
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory port

module stack_op_controller
    import stack_ctrl_pkg::*;
#(
    parameter int                  REG_BITS    = 32,
    parameter logic [REG_BITS-1:0] STACK_BASE  = 32'h0000_0400,
    parameter logic [REG_BITS-1:0] STACK_LIMIT = 32'h0000_0300
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [1:0]          op,
    output logic                op_ready,
    input  logic [REG_BITS-1:0] wdata0,
    input  logic [REG_BITS-1:0] wdata1,
    output logic                op_done,
    output logic                op_err,
    output logic [REG_BITS-1:0] rdata0,
    output logic [REG_BITS-1:0] rdata1,
    input  logic [REG_BITS-1:0] sp_in,
    output logic [1:0]          stack_update_mode,
    output logic                mem_req,
    output logic                mem_we,
    output logic [REG_BITS-1:0] mem_addr,
    output logic [REG_BITS-1:0] mem_wdata,
    input  logic [REG_BITS-1:0] mem_rdata,
    input  logic                mem_ack
);

    state_e              state_q, state_d;
    stack_op_e           op_q;
    logic [REG_BITS-1:0] sp_q;
    logic [REG_BITS-1:0] wd0_q;
    logic [REG_BITS-1:0] wd1_q;
    logic [REG_BITS-1:0] rdata0_q;
    logic [REG_BITS-1:0] rdata1_q;

    logic                accept;
    logic                cap0;
    logic                cap1;
    logic                bounds_viol;
    sp_mode_e            mode;

    logic [REG_BITS-1:0] sp_m1;
    logic [REG_BITS-1:0] sp_m2;
    logic [REG_BITS-1:0] sp_p1;

    // Address arithmetic is modulo 2^REG_BITS; with checking enabled the
    // bounds test guarantees it never actually wraps.
    assign sp_m1 = sp_q - REG_BITS'(1);
    assign sp_m2 = sp_q - REG_BITS'(2);
    assign sp_p1 = sp_q + REG_BITS'(1);

`ifdef STACK_OP_BOUNDS_CHECK_EN
    stack_bounds_check #(
        .REG_BITS    (REG_BITS),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bounds (
        .op        (op_q),
        .sp        (sp_q),
        .violation (bounds_viol)
    );
`else
    // Window parameters only matter to the checker.
    logic unused_bounds;
    assign unused_bounds = ^{STACK_BASE, STACK_LIMIT};
    assign bounds_viol   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_PUSH;
            sp_q     <= '0;
            wd0_q    <= '0;
            wd1_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= stack_op_e'(op);
                sp_q  <= sp_in;
                wd0_q <= wdata0;
                wd1_q <= wdata1;
            end
            if (cap0) begin
                rdata0_q <= mem_rdata;
            end
            if (cap1) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cap0      = 1'b0;
        cap1      = 1'b0;
        op_done   = 1'b0;
        op_err    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mode      = MODE_HOLD;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    accept  = 1'b1;
                    state_d = S_CHK;
                end
            end

            S_CHK: begin
                if (bounds_viol) begin
                    op_done = 1'b1;
                    op_err  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MEM0;
                end
            end

            // First access: the only one for PUSH/POP, the upper slot for
            // CALL/RET (return PC lives above the frame pointer).
            S_MEM0: begin
                mem_req = 1'b1;
                case (op_q)
                    OP_PUSH, OP_CALL: begin
                        mem_we    = 1'b1;
                        mem_addr  = sp_m1;
                        mem_wdata = wd0_q;
                    end
                    OP_POP:  mem_addr = sp_q;
                    OP_RET:  mem_addr = sp_p1;
                    default: mem_addr = sp_q;
                endcase
                if (mem_ack) begin
                    cap0    = (op_q == OP_POP) || (op_q == OP_RET);
                    state_d = ((op_q == OP_PUSH) || (op_q == OP_POP)) ? S_UPD : S_MEM1;
                end
            end

            // Second access, reached only by CALL and RET.
            S_MEM1: begin
                mem_req = 1'b1;
                if (op_q == OP_CALL) begin
                    mem_we    = 1'b1;
                    mem_addr  = sp_m2;
                    mem_wdata = wd1_q;
                end else begin
                    mem_addr = sp_q;
                end
                if (mem_ack) begin
                    cap1    = (op_q == OP_RET);
                    state_d = S_UPD;
                end
            end

            // RET needs +2 but the SP register only steps by 1 upward, so it
            // takes two +1 cycles and reports completion on the second.
            S_UPD: begin
                case (op_q)
                    OP_PUSH: mode = MODE_DEC1;
                    OP_CALL: mode = MODE_DEC2;
                    default: mode = MODE_INC1;
                endcase
                if (op_q == OP_RET) begin
                    state_d = S_UPD2;
                end else begin
                    op_done = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_UPD2: begin
                mode    = MODE_INC1;
                op_done = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign op_ready          = (state_q == S_IDLE);
    assign stack_update_mode = mode;
    assign rdata0            = rdata0_q;
    assign rdata1            = rdata1_q;

endmodule

// File: tb/tb_stack_op_controller.sv
// tb/tb_stack_op_controller.sv - directed self-checking bench for stack_op_controller

module tb_stack_op_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_ready;
    logic [31:0] wdata0, wdata1;
    logic        op_done, op_err;
    logic [31:0] rdata0, rdata1;
    logic [31:0] sp_in;
    logic [1:0]  stack_update_mode;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Environment: SP register, stack memory with programmable ack delay, logs.
    logic [31:0] sp_reg;
    logic        sp_set = 1'b0;
    logic [31:0] sp_set_val = 32'h0;
    logic        mem_ld = 1'b0;
    logic [10:0] mem_ld_addr = 11'h0;
    logic [31:0] mem_ld_data = 32'h0;
    logic        log_clr = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] mem [0:2047];
    logic [31:0] wr_addr_log [0:15];
    logic [31:0] wr_data_log [0:15];
    logic [31:0] rd_addr_log [0:15];

    always #5 clk = ~clk;

    assign sp_in     = sp_reg;
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr[10:0]];

    always @(posedge clk) begin
        if (sp_set) sp_reg <= sp_set_val;
        else begin
            case (stack_update_mode)
                2'b01:   sp_reg <= sp_reg + 32'd1;
                2'b10:   sp_reg <= sp_reg - 32'd2;
                2'b11:   sp_reg <= sp_reg - 32'd1;
                default: ;
            endcase
        end
        if (mem_ld) mem[mem_ld_addr] <= mem_ld_data;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem[mem_addr[10:0]] <= mem_wdata;
                wr_addr_log[wr_cnt[3:0]] <= mem_addr;
                wr_data_log[wr_cnt[3:0]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_addr_log[rd_cnt[3:0]] <= mem_addr;
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (log_clr) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    end

    stack_op_controller dut (
        .clk               (clk),
        .reset             (reset),
        .op_valid          (op_valid),
        .op                (op),
        .op_ready          (op_ready),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .op_done           (op_done),
        .op_err            (op_err),
        .rdata0            (rdata0),
        .rdata1            (rdata1),
        .sp_in             (sp_in),
        .stack_update_mode (stack_update_mode),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    task automatic prep(input logic [31:0] sp, input int delay);
        @(negedge clk);
        sp_set = 1'b1; sp_set_val = sp; log_clr = 1'b1; ack_delay = delay;
        @(negedge clk);
        sp_set = 1'b0; log_clr = 1'b0;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_ld = 1'b1; mem_ld_addr = a; mem_ld_data = d;
        @(negedge clk);
        mem_ld = 1'b0;
    endtask

    // Issues one op and watches it cycle by cycle; the accept cycle is cycle 0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] w0, input logic [31:0] w1,
                          output int lat, output logic err, output int mc,
                          output logic [1:0] ms, output int rc);
        lat = -1; err = 1'b0; mc = 0; ms = 2'b00; rc = 0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++; $display("FAIL run_op_ready got %b want 1", op_ready);
        end
        op = o; wdata0 = w0; wdata1 = w1; op_valid = 1'b1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) op_valid = 1'b0;
            if (stack_update_mode !== 2'b00) begin mc++; ms = stack_update_mode; end
            if (mem_req === 1'b1) rc++;
            if (op_done === 1'b1) begin lat = n; err = op_err; end
        end
        checks++;
        if (lat < 0) begin
            errors++; $display("FAIL run_op_timeout op %0d no op_done within 40 cycles", o);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; op_valid = 1'b0; op = 2'b00; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_op_done got %b want 0", op_done); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err got %b want 0", op_err); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl got %b want 00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (stack_update_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got %b want 00", stack_update_mode); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", rdata0, rdata1); end
    endtask

    task automatic test_push;
        int lat, mc, rc; logic err; logic [1:0] ms;
        prep(32'h400, 0);
        run_op(2'b00, 32'hAA, 32'h0, lat, err, mc, ms, rc);
        checks++; if (lat != 3 || err !== 1'b0) begin errors++; $display("FAIL push_latency got %0d err %b want 3 err 0", lat, err); end
        checks++; if (mc != 1 || ms !== 2'b11) begin errors++; $display("FAIL push_mode got %0d cycles of %b want 1 of 11", mc, ms); end
        @(negedge clk);
        checks++; if (wr_cnt != 1 || wr_addr_log[0] !== 32'h3FF || wr_data_log[0] !== 32'hAA) begin
            errors++; $display("FAIL push_write got n=%0d %h<=%h want n=1 3ff<=aa", wr_cnt, wr_addr_log[0], wr_data_log[0]); end
        checks++; if (sp_in !== 32'h3FF) begin errors++; $display("FAIL push_sp got %h want 3ff", sp_in); end
        checks++; if (stack_update_mode !== 2'b00 || op_ready !== 1'b1) begin
            errors++; $display("FAIL push_after got mode %b ready %b want 00 1", stack_update_mode, op_ready); end
    endtask

    task automatic test_call_ret;
        int lat, mc, rc; logic err; logic [1:0] ms;
        prep(32'h3FE, 2);
        run_op(2'b10, 32'h40, 32'h80, lat, err, mc, ms, rc);
        checks++; if (lat != 8 || err !== 1'b0) begin errors++; $display("FAIL call_latency got %0d err %b want 8 err 0", lat, err); end
        checks++; if (mc != 1 || ms !== 2'b10 || rc != 6) begin
            errors++; $display("FAIL call_mode got %0d x %b req %0d want 1 x 10 req 6", mc, ms, rc); end
        @(negedge clk);
        checks++; if (sp_in !== 32'h3FC) begin errors++; $display("FAIL call_sp got %h want 3fc", sp_in); end
        checks++; if (wr_cnt != 2 || wr_addr_log[0] !== 32'h3FD || wr_data_log[0] !== 32'h40 ||
                      wr_addr_log[1] !== 32'h3FC || wr_data_log[1] !== 32'h80) begin
            errors++; $display("FAIL call_writes got n=%0d %h<=%h %h<=%h want 2 3fd<=40 3fc<=80",
                               wr_cnt, wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]); end
        run_op(2'b11, 32'h0, 32'h0, lat, err, mc, ms, rc);
        checks++; if (lat != 9 || err !== 1'b0) begin errors++; $display("FAIL ret_latency got %0d err %b want 9 err 0", lat, err); end
        checks++; if (mc != 2 || ms !== 2'b01) begin errors++; $display("FAIL ret_mode got %0d x %b want 2 x 01", mc, ms); end
        checks++; if (rdata0 !== 32'h40 || rdata1 !== 32'h80) begin
            errors++; $display("FAIL ret_rdata got %h/%h want 40/80", rdata0, rdata1); end
        @(negedge clk);
        checks++; if (rd_cnt != 2 || rd_addr_log[0] !== 32'h3FD || rd_addr_log[1] !== 32'h3FC) begin
            errors++; $display("FAIL ret_reads got n=%0d %h %h want 2 3fd 3fc", rd_cnt, rd_addr_log[0], rd_addr_log[1]); end
        checks++; if (sp_in !== 32'h3FE) begin errors++; $display("FAIL ret_sp got %h want 3fe", sp_in); end
    endtask

    task automatic test_pop_bounds;
        int lat, mc, rc; logic err; logic [1:0] ms;
        preload(11'h400, 32'h1234);
        prep(32'h400, 0);
        run_op(2'b01, 32'h0, 32'h0, lat, err, mc, ms, rc);
        @(negedge clk);
`ifdef STACK_OP_BOUNDS_CHECK_EN
        checks++; if (lat != 1 || err !== 1'b1) begin errors++; $display("FAIL pop_err got lat %0d err %b want 1 1", lat, err); end
        checks++; if (rc != 0 || mc != 0) begin errors++; $display("FAIL pop_err_side got req %0d mode %0d want 0 0", rc, mc); end
        checks++; if (sp_in !== 32'h400) begin errors++; $display("FAIL pop_err_sp got %h want 400", sp_in); end
`else
        checks++; if (lat != 3 || err !== 1'b0) begin errors++; $display("FAIL pop_ok got lat %0d err %b want 3 0", lat, err); end
        checks++; if (rd_cnt != 1 || rd_addr_log[0] !== 32'h400 || rdata0 !== 32'h1234) begin
            errors++; $display("FAIL pop_read got n=%0d @%h data %h want 1 @400 1234", rd_cnt, rd_addr_log[0], rdata0); end
        checks++; if (mc != 1 || ms !== 2'b01 || sp_in !== 32'h401) begin
            errors++; $display("FAIL pop_sp got %0d x %b sp %h want 1 x 01 sp 401", mc, ms, sp_in); end
`endif
    endtask

    task automatic test_call_limit;
        int lat, mc, rc; logic err; logic [1:0] ms;
        prep(32'h301, 0);
        run_op(2'b10, 32'h11, 32'h22, lat, err, mc, ms, rc);
        @(negedge clk);
`ifdef STACK_OP_BOUNDS_CHECK_EN
        checks++; if (lat != 1 || err !== 1'b1 || rc != 0) begin
            errors++; $display("FAIL call301 got lat %0d err %b req %0d want 1 1 0", lat, err, rc); end
        checks++; if (sp_in !== 32'h301) begin errors++; $display("FAIL call301_sp got %h want 301", sp_in); end
`else
        checks++; if (lat != 4 || err !== 1'b0) begin errors++; $display("FAIL call301 got lat %0d err %b want 4 0", lat, err); end
        checks++; if (sp_in !== 32'h2FF) begin errors++; $display("FAIL call301_sp got %h want 2ff", sp_in); end
`endif
        prep(32'h302, 0);
        run_op(2'b10, 32'h11, 32'h22, lat, err, mc, ms, rc);
        @(negedge clk);
        checks++; if (lat != 4 || err !== 1'b0) begin errors++; $display("FAIL call302 got lat %0d err %b want 4 0", lat, err); end
        checks++; if (sp_in !== 32'h300) begin errors++; $display("FAIL call302_sp got %h want 300", sp_in); end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        prep(32'h3FE, 5);
        @(negedge clk);
        op = 2'b10; wdata0 = 32'h55; wdata1 = 32'h66; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (mem_req === 1'b1 && mem_addr === 32'h3FC) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got no MEM1 want MEM1 within 40"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (op_ready !== 1'b1 || mem_req !== 1'b0 || op_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got ready %b req %b done %b want 1 0 0", op_ready, mem_req, op_done); end
        checks++; if (stack_update_mode !== 2'b00) begin errors++; $display("FAIL rstmid_mode got %b want 00", stack_update_mode); end
        @(negedge clk);
        checks++; if (sp_in !== 32'h3FE) begin errors++; $display("FAIL rstmid_sp got %h want 3fe", sp_in); end
    endtask

    task automatic test_back_to_back;
        int readies = 0, dones = 0;
        prep(32'h400, 0);
        @(negedge clk);
        op = 2'b00; wdata0 = 32'h77; wdata1 = 32'h0; op_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (op_ready === 1'b1) readies++;
            if (op_done === 1'b1) dones++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        @(negedge clk);
        checks++; if (readies != 3 || dones != 3) begin
            errors++; $display("FAIL b2b_count got ready %0d done %0d want 3 3", readies, dones); end
        checks++; if (wr_cnt != 3 || wr_addr_log[0] !== 32'h3FF || wr_addr_log[1] !== 32'h3FE || wr_addr_log[2] !== 32'h3FD) begin
            errors++; $display("FAIL b2b_writes got n=%0d %h %h %h want 3 3ff 3fe 3fd",
                               wr_cnt, wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]); end
        checks++; if (sp_in !== 32'h3FD) begin errors++; $display("FAIL b2b_sp got %h want 3fd", sp_in); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_call_ret();
        test_pop_bounds();
        test_call_limit();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
